isr_iter: RTL
=============

// Module: isr_iter
// PURPOSE
//  Parametrised iterative integer square root unit; next generation of the fixed 64-bit ISR.
//  Computes floor(sqrt(value)) and the remainder for an unsigned WIDTH-bit operand.
//  Resolves BITS_PER_CYCLE root bits per clock using a digit-recurrence method.
//  Uses a start/ready/done handshake, so it sits in the datapath as a multi-cycle
//  functional unit beside the multiplier.
// PARAMETERS
//  WIDTH           64  operand width; even, >=4
//  BITS_PER_CYCLE   1  root bits resolved per clock; 1, 2 or 4; must divide WIDTH/2
// PORTS
//  clock      in   1          single clock, rising edge
//  reset      in   1          asynchronous, active-low; 0 = reset asserted
//  start      in   1          request a new operation; sampled at posedge
//  value      in   WIDTH      unsigned operand; captured on the accepted start
//  ready      out  1          1 = a start on this edge is accepted (state != RUN)
//  result     out  WIDTH/2    floor(sqrt(value))
//  remainder  out  WIDTH/2+1  value - result^2; at most 2*result
//  done       out  1          level; 1 = result/remainder valid; held until the next accepted start
// BEHAVIOUR
//  - Reset (reset==0, any time, asynchronous): state=IDLE, ready=1, done=0, result=0, remainder=0.
//    An operation in flight is discarded.
//  - ITER = WIDTH/(2*BITS_PER_CYCLE).
//  - FSM has three states: IDLE, RUN, DONE.
//    * IDLE --start--> RUN
//    * RUN --counter==ITER-1--> DONE
//    * DONE --start--> RUN
//    * DONE with no start stays in DONE.
//  - Accept: start==1 && ready==1 at posedge.
//    * value is latched into the operand register; partial root and remainder clear to 0.
//    * Iteration counter clears to 0.
//    * done drops to 0 on the same edge.
//  - start in RUN is ignored (ready==0). value changes after accept do not affect the result.
//  - Latency: if accept happens at edge N, done rises at edge N+ITER.
//    result and remainder are updated on that same edge and are stable while done==1.
//  - Per sub-step (BITS_PER_CYCLE per clock), taking operand bit pairs MSB-first:
//    * rem   = (rem<<2) | next_pair
//    * trial = (root<<2) | 1
//    * if rem >= trial: rem -= trial, root = (root<<1)|1; else root = root<<1
//  - Width rules:
//    * rem/trial datapath is WIDTH/2+2 bits, so no overflow.
//    * remainder output is WIDTH/2+1 bits.
//    * All arithmetic is unsigned. A negative literal drives its two's-complement bit pattern.
//  - Back-to-back: start held high in DONE is accepted on that edge; the next op begins without an idle cycle.
//  - In the cycle after accept, ready==0. ready returns to 1 on the edge done rises.
//  - Boundary cases:
//    * value=0 -> result 0, remainder 0.
//    * value=all-ones -> result all-ones (WIDTH/2 bits), remainder 2^(WIDTH/2+1)-2.
// STRUCTURE
//  - isr_pkg holds:
//    * typedef enum isr_state_t {IDLE,RUN,DONE}
//    * localparam-computing function isr_iters(WIDTH,BPC)
//  - Sub-module isr_step (combinational): one recurrence step; inputs rem, root, pair; outputs rem', root'.
//    isr_iter chains BITS_PER_CYCLE instances of isr_step between registers.
//  - isr_iter owns the FSM, iteration counter, operand shift register and output registers.
// TESTING
//  1 reset=0 for 4 cycles, then release -> ready=1, done=0, result=0, remainder=0.
//  2 W=64,BPC=1: value=25, start for 1 cycle -> done exactly 32 edges after accept;
//    result=5, remainder=0.
//  3 value=-24 (0xFFFF_FFFF_FFFF_FFE8) -> result=0xFFFF_FFFF, remainder=0x1_FFFF_FFE7.
//    value=0 -> result 0, remainder 0.
//  4 Start pulses while in RUN, and value changed after accept, with operand 1000
//    -> both ignored; result=31, remainder=39.
//    Start held high in DONE -> back-to-back accept; done low for exactly ITER cycles.
//  5 reset=0 mid-RUN (cycle 10) -> outputs clear immediately; a fresh op on 144 gives result=12, remainder=0.
//  6 W=16,BPC=2 (ITER=4) and W=32,BPC=4 (ITER=4): 10k random operands checked against a
//    $sqrt-free integer model:
//    * result^2 <= value < (result+1)^2
//    * remainder == value - result^2

Source files
------------

// File: rtl/isr_pkg.sv
// Shared types and elaboration helpers for the iterative square-root unit.
package isr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } isr_state_t;

  // Number of clocks needed to resolve all WIDTH/2 root bits.
  function automatic int isr_iters(input int width, input int bpc);
    return width / (2 * bpc);
  endfunction

  function automatic int isr_cnt_w(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/isr_step.sv
// One digit-recurrence step: brings in the next operand bit pair and decides one root bit.
module isr_step #(
  parameter int HW = 32
) (
  input  logic [HW+1:0] rem_i,
  input  logic [HW-1:0] root_i,
  input  logic [1:0]    pair_i,
  output logic [HW+1:0] rem_o,
  output logic [HW-1:0] root_o
);

  logic [HW+1:0] rem_sh_s;
  logic [HW+1:0] trial_s;
  logic          ge_s;

  // Top bits of rem shifted out here are provably zero, so HW+2 bits never overflow.
  always_comb begin
    rem_sh_s = (rem_i << 2) | {{HW{1'b0}}, pair_i};
    trial_s  = {root_i, 2'b01};
    ge_s     = (rem_sh_s >= trial_s);
    if (ge_s) begin
      rem_o = rem_sh_s - trial_s;
    end else begin
      rem_o = rem_sh_s;
    end
    root_o = (root_i << 1) | {{(HW-1){1'b0}}, ge_s};
  end

endmodule

// File: rtl/isr_iter.sv
// Iterative integer square root: floor(sqrt(value)) and remainder, BITS_PER_CYCLE root
// bits per clock, with a start/ready/done handshake.
module isr_iter
  import isr_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     value,
  output logic                 ready,
  output logic [WIDTH/2-1:0]   result,
  output logic [WIDTH/2:0]     remainder,
  output logic                 done
);

  localparam int HW    = WIDTH / 2;
  localparam int RW    = HW + 2;
  localparam int ITER  = isr_iters(WIDTH, BITS_PER_CYCLE);
  localparam int CW    = isr_cnt_w(ITER);
  localparam int SH    = 2 * BITS_PER_CYCLE;

  isr_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [HW-1:0]    root_q, root_d;
  logic [HW-1:0]    result_q, result_d;
  logic [HW:0]      remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             accept_s;
  logic             last_s;

  logic [RW-1:0]    rem_c  [0:BITS_PER_CYCLE];
  logic [HW-1:0]    root_c [0:BITS_PER_CYCLE];

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  // Operand is consumed MSB-first: step g of a clock uses the g-th pair from the top.
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    isr_step #(.HW(HW)) u_step (
      .rem_i  (rem_c[g]),
      .root_i (root_c[g]),
      .pair_i (op_q[WIDTH-1-2*g -: 2]),
      .rem_o  (rem_c[g+1]),
      .root_o (root_c[g+1])
    );
  end

  assign accept_s = start && (state_q != RUN);
  assign last_s   = (cnt_q == CW'(ITER - 1));

  // Next-state, datapath and output-register selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rem_d       = rem_q;
    root_d      = root_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    done_d      = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d = RUN;
          cnt_d   = '0;
          op_d    = value;
          rem_d   = '0;
          root_d  = '0;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        op_d   = op_q << SH;
        rem_d  = rem_c[BITS_PER_CYCLE];
        root_d = root_c[BITS_PER_CYCLE];
        cnt_d  = cnt_q + CW'(1);
        if (last_s) begin
          state_d     = DONE;
          result_d    = root_c[BITS_PER_CYCLE];
          remainder_d = rem_c[BITS_PER_CYCLE][HW:0];
          done_d      = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
    ready_d = (state_d != RUN);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign result    = result_q;
  assign remainder = remainder_q;
  assign done      = done_q;

endmodule
